// File: rtl/alu_seq.sv
// Purpose: registered DLX ALU with status flags and an iterative shift-add unsigned multiply.
// Latency: 1 cycle for single-cycle ops, NBIT cycles for MUL (accept edge to out_valid).
// Backpressure: one-entry output register; in_ready drops while it is held or a multiply runs.
module alu_seq #(
    parameter int NBIT = 32,
    localparam int SHW = $clog2(NBIT)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [NBIT-1:0] alu_in_a,
    input  logic [NBIT-1:0] alu_in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] alu_out,
    output logic            flag_zero,
    output logic            flag_cout,
    output logic            flag_ovf,
    output logic            busy
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SEQ = 4'd8;
    localparam logic [3:0] OP_SNE = 4'd9;
    localparam logic [3:0] OP_SLT = 4'd10;
    localparam logic [3:0] OP_SGT = 4'd11;
    localparam logic [3:0] OP_SLE = 4'd12;
    localparam logic [3:0] OP_SGE = 4'd13;
    localparam logic [3:0] OP_MUL = 4'd14;

    // The counter is SHW bits wide, so the last step index is NBIT-1 and it wraps to 0 afterwards.
    localparam logic [SHW-1:0] CNT_LAST = SHW'(NBIT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        MBUSY = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              accept;
    logic              take;
    logic              load_single;
    logic              load_mul;

    // Single-cycle datapath
    logic [NBIT:0]     add_full;
    logic [NBIT:0]     sub_full;
    logic [SHW-1:0]    shamt;
    logic              cmp_eq;
    logic              cmp_lt;
    logic [NBIT-1:0]   sc_res;
    logic              sc_cout;
    logic              sc_ovf;

    // Multiply datapath
    logic [2*NBIT-1:0] mul_mcand;
    logic [NBIT-1:0]   mul_mplier;
    logic [2*NBIT-1:0] mul_acc;
    logic [2*NBIT-1:0] mul_acc_step;
    logic [SHW-1:0]    mul_cnt;

    assign in_ready    = (state_q == IDLE) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign take        = out_valid && out_ready;
    assign load_single = accept && (alu_op != OP_MUL);
    assign load_mul    = (state_q == MBUSY) && (mul_cnt == CNT_LAST);
    assign busy        = (state_q == MBUSY);

    // Subtraction as A + ~B + 1 so the carry out is directly the not-borrow flag.
    assign add_full = {1'b0, alu_in_a} + {1'b0, alu_in_b};
    assign sub_full = {1'b0, alu_in_a} + {1'b0, ~alu_in_b} + {{NBIT{1'b0}}, 1'b1};
    assign shamt    = alu_in_b[SHW-1:0];
    assign cmp_eq   = (alu_in_a == alu_in_b);
    assign cmp_lt   = ($signed(alu_in_a) < $signed(alu_in_b));

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    assign mul_acc_step = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;

    // Single-cycle result and flags; reserved opcode falls through to zero with no flags.
    always_comb begin
        sc_res  = '0;
        sc_cout = 1'b0;
        sc_ovf  = 1'b0;
        case (alu_op)
            OP_ADD: begin
                sc_res  = add_full[NBIT-1:0];
                sc_cout = add_full[NBIT];
                sc_ovf  = (alu_in_a[NBIT-1] == alu_in_b[NBIT-1]) &&
                          (add_full[NBIT-1] != alu_in_a[NBIT-1]);
            end
            OP_SUB: begin
                sc_res  = sub_full[NBIT-1:0];
                sc_cout = sub_full[NBIT];
                sc_ovf  = (alu_in_a[NBIT-1] != alu_in_b[NBIT-1]) &&
                          (sub_full[NBIT-1] != alu_in_a[NBIT-1]);
            end
            OP_AND: sc_res = alu_in_a & alu_in_b;
            OP_OR:  sc_res = alu_in_a | alu_in_b;
            OP_XOR: sc_res = alu_in_a ^ alu_in_b;
            OP_SLL: sc_res = alu_in_a << shamt;
            OP_SRL: sc_res = alu_in_a >> shamt;
            OP_SRA: sc_res = $signed(alu_in_a) >>> shamt;
            OP_SEQ: sc_res = {{(NBIT-1){1'b0}}, cmp_eq};
            OP_SNE: sc_res = {{(NBIT-1){1'b0}}, !cmp_eq};
            OP_SLT: sc_res = {{(NBIT-1){1'b0}}, cmp_lt};
            OP_SGT: sc_res = {{(NBIT-1){1'b0}}, !cmp_lt && !cmp_eq};
            OP_SLE: sc_res = {{(NBIT-1){1'b0}}, cmp_lt || cmp_eq};
            OP_SGE: sc_res = {{(NBIT-1){1'b0}}, !cmp_lt};
            default: begin
                sc_res  = '0;
                sc_cout = 1'b0;
                sc_ovf  = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a MUL accept enters MBUSY, the final step returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && (alu_op == OP_MUL)) state_d = MBUSY;
            MBUSY:   if (mul_cnt == CNT_LAST)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiply operand latch, accumulator and step counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_acc    <= '0;
            mul_cnt    <= '0;
        end else if (accept && (alu_op == OP_MUL)) begin
            mul_mcand  <= {{NBIT{1'b0}}, alu_in_a};
            mul_mplier <= alu_in_b;
            mul_acc    <= '0;
            mul_cnt    <= '0;
        end else if (state_q == MBUSY) begin
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_acc    <= mul_acc_step;
            mul_cnt    <= mul_cnt + 1'b1;
        end
    end

    // Output register: a new load wins over a take; otherwise hold until taken
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid <= 1'b0;
            alu_out   <= '0;
            flag_zero <= 1'b0;
            flag_cout <= 1'b0;
            flag_ovf  <= 1'b0;
        end else if (load_mul) begin
            out_valid <= 1'b1;
            alu_out   <= mul_acc_step[NBIT-1:0];
            flag_zero <= (mul_acc_step[NBIT-1:0] == '0);
            flag_cout <= 1'b0;
            flag_ovf  <= |mul_acc_step[2*NBIT-1:NBIT];
        end else if (load_single) begin
            out_valid <= 1'b1;
            alu_out   <= sc_res;
            flag_zero <= (sc_res == '0);
            flag_cout <= sc_cout;
            flag_ovf  <= sc_ovf;
        end else if (take) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the DLX combinational ALU.
- Accepts operations through a valid/ready input handshake and returns results through a valid/ready output handshake with a one-entry output register.
- Adds status flags and a multi-cycle iterative unsigned multiply.
- Sits between the DLX execute-stage operand latches and the memory stage; a UVM-style bench drives it through an interface.

Parameters:
- NBIT, 32, datapath width. Must be a power of two, at least 8.
- SHW, $clog2(NBIT), shift-amount width (derived; not overridden).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation this cycle
- alu_op  in  4  operation code
- alu_in_a  in  NBIT  operand A
- alu_in_b  in  NBIT  operand B
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  consumer takes the result this cycle
- alu_out  out  NBIT  result
- flag_zero  out  1  alu_out == 0
- flag_cout  out  1  carry out (ADD), not-borrow (SUB), else 0
- flag_ovf  out  1  signed overflow (ADD/SUB), product exceeds NBIT bits (MUL), else 0
- busy  out  1  multiply in progress

Behaviour:
- Clocking and reset: one clock (CLK); reset RST is asynchronous, active-low.
- Reset state: FSM in IDLE, counter 0. out_valid, alu_out, all flags and busy are 0. in_ready is 1 once RST deasserts.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SEQ, 9 SNE, 10 SLT, 11 SGT, 12 SLE, 13 SGE, 14 MUL, 15 reserved.
  - Reserved opcode 15 completes in one cycle with result 0 and all flags 0 except zero.
- Shifts use alu_in_b[SHW-1:0]; the upper bits of B are ignored.
- Compares (SEQ..SGE) are two's-complement signed and return 1 or 0 zero-extended to NBIT.
- ADD/SUB results wrap modulo 2^NBIT.
- MUL is unsigned; alu_out is the low NBIT bits of the product.
- in_ready = (state == IDLE) && (!out_valid || out_ready). An operation is accepted on an edge where in_valid && in_ready.
- Single-cycle ops: result and flags are loaded into the output register on the accept edge. out_valid is high in the following cycle (latency 1). Back-to-back throughput is 1 per cycle while out_ready = 1.
- MUL FSM, states IDLE and MBUSY:
  - Accept edge: latch A, B and a 2*NBIT accumulator = 0, set counter = 0, move to MBUSY.
  - Each MBUSY edge does one shift-add step and increments the counter.
  - On the edge where counter == NBIT-1 the final step completes: the output register is loaded and the FSM returns to IDLE.
  - Result latency is NBIT cycles. busy = 1 throughout MBUSY. in_ready = 0 throughout MBUSY.
- Output register:
  - Holds value and flags stable while out_valid && !out_ready.
  - Clears out_valid on a take (out_valid && out_ready) unless a new result loads on the same edge.
  - Load has priority over clear.
- Simultaneous take and accept: permitted, with no bubble.
- MUL accepted while the previous result is being taken: the output register is empty during MBUSY, so there is no load conflict.
- in_valid while not ready: ignored. The producer must hold its operands; the block samples only on accept.
- Reset mid-MUL: the multiply is aborted immediately, all state clears, and no result is produced.

Test Plan:
- Reset with RST=0 during traffic, then release -> out_valid=0, alu_out=0, flags 0, busy=0, in_ready=1 in the first cycle after release.
- NBIT=8:
  - ADD 0x7F+0x01 -> 0x80, ovf=1, cout=0, one cycle later.
  - ADD 0xFF+0x01 -> 0x00, zero=1, cout=1, ovf=0.
  - SUB 0x00-0x01 -> 0xFF, cout=0.
- NBIT=8, shifts and compares:
  - SRA 0x80 by B=0x09 (only 1 used) -> 0xC0.
  - SLL 0x01 by 7 -> 0x80.
  - SLT 0xFF,0x01 -> 0x01.
  - SGE 0x01,0xFF -> 0x01.
- NBIT=8, MUL 0x10*0x11 -> alu_out 0x10, ovf=1; out_valid exactly 8 cycles after accept; in_ready=0 and busy=1 for those cycles.
- Backpressure: out_ready=0 for 5 cycles with a continuous in_valid stream -> exactly one extra accept, then in_ready=0; alu_out stable. out_ready=1 then drains in order with no loss or duplication, 1 per cycle.
- MUL 0x03*0x05 with RST pulsed low at cycle 4 -> no out_valid ever; after release, ADD 2+3 -> 0x05 in 1 cycle.
